// File: rtl/timer_apb_seq.sv
// timer_apb_seq: APB master that programs the timer, services tim_int and reloads compare in periodic mode
// Ports: sys_clk/sys_rst (async, active-high); start/stop pulses; periodic, period, div_en, div_val sampled at start;
// tim_int level interrupt; psel/penable/pwrite/paddr/pwdata/pstrb/pready/pslverr APB master port;
// busy/active status, sticky err, evt_cnt serviced-interrupt count.
// Optional: define TIMER_APB_SEQ_TIMEOUT_EN to abort a transfer after TIMEOUT cycles without pready.
module timer_apb_seq #(
  parameter logic [11:0] ADDR_TCR   = 12'h000,
  parameter logic [11:0] ADDR_TDR0  = 12'h004,
  parameter logic [11:0] ADDR_TDR1  = 12'h008,
  parameter logic [11:0] ADDR_TCMP0 = 12'h00C,
  parameter logic [11:0] ADDR_TCMP1 = 12'h010,
  parameter logic [11:0] ADDR_TIER  = 12'h014,
  parameter logic [11:0] ADDR_TISR  = 12'h018,
  parameter int          TIMEOUT    = 256
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        stop,
  input  logic        periodic,
  input  logic [63:0] period,
  input  logic        div_en,
  input  logic [3:0]  div_val,
  input  logic        tim_int,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [11:0] paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic        pslverr,
  output logic        busy,
  output logic        active,
  output logic        err,
  output logic [15:0] evt_cnt
);
`ifdef TIMER_APB_SEQ_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, CFG, ACTIVE, SVC, STOP} state_t;
  typedef enum logic [1:0] {GAP, SETUP, ACCESS} phase_t;
  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [2:0]  step_q, step_d, n_wr;
  logic [63:0] cmp_q, cmp_d, per_val_q, per_val_d;
  logic        per_q, per_d, den_q, den_d, stop_q, stop_d, err_q, err_d;
  logic [3:0]  dval_q, dval_d;
  logic [15:0] evt_q, evt_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic [11:0] addr;
  logic [31:0] data;
  logic        stop_pend, to_hit;
  assign psel    = phase_q != GAP;
  assign penable = phase_q == ACCESS;
  assign pwrite  = psel;
  assign pstrb   = psel ? 4'hF : 4'h0;
  assign paddr   = psel ? addr : 12'h000;
  assign pwdata  = psel ? data : 32'h0;
  assign busy    = state_q != IDLE;
  assign active  = state_q == ACTIVE;
  assign err     = err_q;
  assign evt_cnt = evt_q;
  assign stop_pend = stop_q | stop;
  assign to_hit = TO_EN && phase_q == ACCESS && !pready && wcnt_q == 32'(TIMEOUT - 1);
  assign n_wr = state_q == CFG ? 3'd7 : (state_q == SVC && per_q) ? 3'd3 : 3'd2;
  // Write sequence table: address/data of the write at position step_q within each state
  always_comb begin
    addr = ADDR_TCR;
    data = 32'h0;
    case (state_q)
      CFG: case (step_q)
        3'd0: addr = ADDR_TCR;
        3'd1: addr = ADDR_TDR0;
        3'd2: addr = ADDR_TDR1;
        3'd3: begin addr = ADDR_TCMP0; data = cmp_q[31:0]; end
        3'd4: begin addr = ADDR_TCMP1; data = cmp_q[63:32]; end
        3'd5: begin addr = ADDR_TIER; data = 32'h1; end
        default: data = {20'b0, dval_q, 6'b0, den_q, 1'b1};
      endcase
      SVC: case (step_q)
        3'd0: begin addr = ADDR_TISR; data = 32'h1; end
        3'd1: begin addr = per_q ? ADDR_TCMP0 : ADDR_TCR; data = per_q ? cmp_q[31:0] : 32'h0; end
        default: begin addr = ADDR_TCMP1; data = cmp_q[63:32]; end
      endcase
      STOP: begin
        addr = step_q == 3'd0 ? ADDR_TCR : ADDR_TISR;
        data = step_q == 3'd0 ? 32'h0 : 32'h1;
      end
      default: ;
    endcase
  end
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    step_d    = step_q;
    cmp_d     = cmp_q;
    per_val_d = per_val_q;
    per_d     = per_q;
    den_d     = den_q;
    dval_d    = dval_q;
    stop_d    = stop_q;
    err_d     = err_q;
    evt_d     = evt_q;
    wcnt_d    = (phase_q == ACCESS && !pready) ? wcnt_q + 32'd1 : 32'd0;
    if ((state_q == CFG || state_q == SVC) && stop) stop_d = 1'b1;
    case (state_q)
      IDLE: if (start) begin
        per_d     = periodic;
        per_val_d = period;
        cmp_d     = period;
        den_d     = div_en;
        dval_d    = div_val;
        err_d     = 1'b0;
        evt_d     = 16'h0;
        stop_d    = 1'b0;
        state_d   = CFG;
        phase_d   = SETUP;
        step_d    = 3'd0;
      end
      ACTIVE: if (stop || tim_int) begin
        state_d = stop ? STOP : SVC;
        phase_d = SETUP;
        step_d  = 3'd0;
      end
      default: begin
        if (phase_q == SETUP) phase_d = ACCESS;
        else if (phase_q == ACCESS) begin
          if (pready && pslverr || to_hit) begin
            err_d   = 1'b1;
            state_d = IDLE;
            phase_d = GAP;
            stop_d  = 1'b0;
          end else if (pready) begin
            phase_d = GAP;
            step_d  = step_q + 3'd1;
            if (state_q == SVC && step_q == 3'd0) begin
              evt_d = evt_q + 16'(evt_q != 16'hFFFF);
              cmp_d = cmp_q + per_val_q;
            end
          end
        end else if (state_q != STOP && stop_pend) begin
          state_d = STOP;
          phase_d = SETUP;
          step_d  = 3'd0;
          stop_d  = 1'b0;
        end else if (step_q == n_wr) begin
          state_d = (state_q == CFG || (state_q == SVC && per_q)) ? ACTIVE : IDLE;
          step_d  = 3'd0;
        end else phase_d = SETUP;
      end
    endcase
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      phase_q   <= GAP;
      step_q    <= 3'd0;
      cmp_q     <= 64'h0;
      per_val_q <= 64'h0;
      per_q     <= 1'b0;
      den_q     <= 1'b0;
      dval_q    <= 4'h0;
      stop_q    <= 1'b0;
      err_q     <= 1'b0;
      evt_q     <= 16'h0;
      wcnt_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      cmp_q     <= cmp_d;
      per_val_q <= per_val_d;
      per_q     <= per_d;
      den_q     <= den_d;
      dval_q    <= dval_d;
      stop_q    <= stop_d;
      err_q     <= err_d;
      evt_q     <= evt_d;
      wcnt_q    <= wcnt_d;
    end
  end
endmodule

// File: tb/tb_timer_apb_seq.sv
// tb_timer_apb_seq: directed self-checking bench for timer_apb_seq
module tb_timer_apb_seq;
  logic        sys_clk = 1'b0, sys_rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, periodic = 1'b0, div_en = 1'b0, tim_int = 1'b0;
  logic [63:0] period = 64'h0;
  logic [3:0]  div_val = 4'h0;
  logic        psel, penable, pwrite, pready = 1'b1, pslverr, busy, active, err;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [15:0] evt_cnt;
  logic        inj = 1'b0, prev_done = 1'b0;
  logic [11:0] sa;
  logic [31:0] sd;
  logic [11:0] wa[$];
  logic [31:0] wd[$];
  int          n_chk = 0, n_pass = 0, bad = 0, c;
  always #5 sys_clk = ~sys_clk;
  assign pslverr = inj && psel && penable && paddr == 12'h008;
  timer_apb_seq #(.TIMEOUT(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop), .periodic(periodic),
    .period(period), .div_en(div_en), .div_val(div_val), .tim_int(tim_int),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .pslverr(pslverr), .busy(busy), .active(active), .err(err), .evt_cnt(evt_cnt)
  );
  always @(posedge sys_clk) begin
    if (prev_done && psel) bad++;
    prev_done <= psel && penable && pready;
    if (psel && !penable) begin sa <= paddr; sd <= pwdata; end
    if (psel && penable && (paddr != sa || pwdata != sd || !pwrite || pstrb != 4'hF)) bad++;
    if (psel && penable && pready) begin wa.push_back(paddr); wd.push_back(pwdata); end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask
  task automatic go(input logic per, input logic [63:0] p, input logic de, input logic [3:0] dv);
    periodic = per; period = p; div_en = de; div_val = dv; start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic wait_for(input logic want_active, input string tag, output int cyc);
    cyc = 0;
    while ((want_active ? !active : busy) && cyc < 500) begin tick; cyc++; end
    chk({tag, "_to"}, 64'(cyc < 500), 64'h1);
  endtask
  task automatic exp_wr(input string tag, input logic [11:0] a, input logic [31:0] d);
    chk({tag, "_n"}, 64'(wa.size() != 0), 64'h1);
    if (wa.size() != 0) begin
      chk({tag, "_a"}, 64'(wa.pop_front()), 64'(a));
      chk({tag, "_d"}, 64'(wd.pop_front()), 64'(d));
    end
  endtask
  initial begin
    tick; tick;
    chk("rst_apb", {psel, penable, pwrite, paddr, pwdata, pstrb}, 64'h0);
    chk("rst_st", {busy, active, err, evt_cnt}, 64'h0);
    sys_rst = 1'b0;
    tick;
    go(1'b1, 64'h0000_0001_0000_0010, 1'b1, 4'h3);
    wait_for(1'b1, "cfg", c);
    chk("cfg_cyc", 64'(c), 64'd21);
    exp_wr("c0", 12'h000, 32'h0);
    exp_wr("c1", 12'h004, 32'h0);
    exp_wr("c2", 12'h008, 32'h0);
    exp_wr("c3", 12'h00C, 32'h10);
    exp_wr("c4", 12'h010, 32'h1);
    exp_wr("c5", 12'h014, 32'h1);
    exp_wr("c6", 12'h000, 32'h303);
    stop = 1'b1; tick; stop = 1'b0;
    wait_for(1'b0, "stp", c);
    exp_wr("s0", 12'h000, 32'h0);
    exp_wr("s1", 12'h018, 32'h1);
    go(1'b1, 64'd100, 1'b0, 4'h0);
    pready = 1'b0;
    repeat (4) tick;
    chk("wait_ctl", {psel, penable, paddr}, {2'b11, 12'h000});
    pready = 1'b1;
    wait_for(1'b1, "cfg2", c);
    exp_wr("p0", 12'h000, 32'h0);
    exp_wr("p1", 12'h004, 32'h0);
    exp_wr("p2", 12'h008, 32'h0);
    exp_wr("p3", 12'h00C, 32'd100);
    exp_wr("p4", 12'h010, 32'h0);
    exp_wr("p5", 12'h014, 32'h1);
    exp_wr("p6", 12'h000, 32'h1);
    for (int i = 2; i <= 4; i++) begin
      tim_int = 1'b1; tick; tim_int = 1'b0;
      wait_for(1'b1, "svc", c);
      exp_wr("v_isr", 12'h018, 32'h1);
      exp_wr("v_lo", 12'h00C, 32'(100 * i));
      exp_wr("v_hi", 12'h010, 32'h0);
    end
    chk("evt3", 64'(evt_cnt), 64'd3);
    stop = 1'b1; tim_int = 1'b1; tick; stop = 1'b0; tim_int = 1'b0;
    wait_for(1'b0, "stpint", c);
    exp_wr("si0", 12'h000, 32'h0);
    exp_wr("si1", 12'h018, 32'h1);
    chk("si_none", 64'(wa.size()), 64'd0);
    chk("si_evt", 64'(evt_cnt), 64'd3);
    go(1'b0, 64'd5, 1'b0, 4'h0);
    chk("os_clr", 64'(evt_cnt), 64'd0);
    wait_for(1'b1, "os", c);
    wa.delete(); wd.delete();
    tim_int = 1'b1; tick; tim_int = 1'b0;
    wait_for(1'b0, "os_end", c);
    exp_wr("o0", 12'h018, 32'h1);
    exp_wr("o1", 12'h000, 32'h0);
    chk("os_st", {busy, evt_cnt}, 64'd1);
    go(1'b1, 64'd7, 1'b0, 4'h0);
    repeat (4) tick;
    stop = 1'b1; tick; stop = 1'b0;
    wait_for(1'b0, "lat", c);
    exp_wr("l0", 12'h000, 32'h0);
    exp_wr("l1", 12'h004, 32'h0);
    exp_wr("l2", 12'h000, 32'h0);
    exp_wr("l3", 12'h018, 32'h1);
    chk("l_none", 64'(wa.size()), 64'd0);
    inj = 1'b1;
    go(1'b1, 64'd9, 1'b0, 4'h0);
    c = 0;
    while (!(psel && penable && paddr == 12'h008) && c < 100) begin tick; c++; end
    chk("se_reach", 64'(c < 100), 64'h1);
    tick;
    chk("se_st", {busy, err, psel}, {1'b0, 1'b1, 1'b0});
    repeat (10) tick;
    exp_wr("e0", 12'h000, 32'h0);
    exp_wr("e1", 12'h004, 32'h0);
    exp_wr("e2", 12'h008, 32'h0);
    chk("se_none", 64'(wa.size()), 64'd0);
    inj = 1'b0;
    go(1'b1, 64'd9, 1'b0, 4'h0);
    chk("err_clr", {err, psel}, {1'b0, 1'b1});
    #2 sys_rst = 1'b1;
    #1 chk("arst", {psel, penable, busy}, 64'h0);
    tick; sys_rst = 1'b0; tick;
    wa.delete(); wd.delete();
`ifdef TIMER_APB_SEQ_TIMEOUT_EN
    pready = 1'b0;
    go(1'b1, 64'd9, 1'b0, 4'h0);
    repeat (8) tick;
    chk("to_wait", {psel, penable, err}, {1'b1, 1'b1, 1'b0});
    tick;
    chk("to_abort", {psel, err, busy}, {1'b0, 1'b1, 1'b0});
    pready = 1'b1;
`endif
    chk("protocol", 64'(bad), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
